// File: rtl/armleocpu_mul_iter_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding and
// the elaboration-time legality check for BITS_PER_CYCLE.
package armleocpu_mul_iter_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_FIX  = 2'd2
    } mul_state_t;

    function automatic bit mul_bpc_legal(input int unsigned width, input int unsigned bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8)) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/armleocpu_mul_iter.sv
// Iterative signed/unsigned multiplier producing the full 2*WIDTH-bit product.
// Works on operand magnitudes, then applies the sign in a final FIX cycle.
module armleocpu_mul_iter
    import armleocpu_mul_iter_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 kill,
    input  logic                 signed0,
    input  logic                 signed1,
    input  logic [WIDTH-1:0]     factor0,
    input  logic [WIDTH-1:0]     factor1,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned ITER = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned PW   = WIDTH + BITS_PER_CYCLE;
    localparam int unsigned RW   = 2 * WIDTH;

    if (!mul_bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
        $error("armleocpu_mul_iter: BITS_PER_CYCLE must be 1/2/4/8 and divide WIDTH");
    end

    mul_state_t          state_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [RW-1:0]       acc_q;
    logic [CW-1:0]       count_q;
    logic                neg_q;
    logic [RW-1:0]       result_q;
    logic                ready_q;

    logic [WIDTH-1:0]    mag0;
    logic [WIDTH-1:0]    mag1;
    logic                neg_d;
    logic [PW-1:0]       pp;
    logic [RW-1:0]       addend;

    // Magnitudes are unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        mag0   = (signed0 && factor0[WIDTH-1]) ? (~factor0 + 1'b1) : factor0;
        mag1   = (signed1 && factor1[WIDTH-1]) ? (~factor1 + 1'b1) : factor1;
        neg_d  = (signed0 & factor0[WIDTH-1]) ^ (signed1 & factor1[WIDTH-1]);
        pp     = PW'(mcand_q) * PW'(mplier_q[BITS_PER_CYCLE-1:0]);
        addend = RW'(pp) << (count_q * BITS_PER_CYCLE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                MUL_IDLE: begin
                    if (valid && !kill) begin
                        mcand_q  <= mag0;
                        mplier_q <= mag1;
                        neg_q    <= neg_d;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= MUL_CALC;
                    end
                end
                MUL_CALC: begin
                    if (kill) begin
                        state_q <= MUL_IDLE;
                    end else begin
                        acc_q    <= acc_q + addend;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                        count_q  <= count_q + 1'b1;
                        if (count_q == CW'(ITER - 1))
                            state_q <= MUL_FIX;
                    end
                end
                MUL_FIX: begin
                    if (!kill) begin
                        result_q <= neg_q ? (~acc_q + 1'b1) : acc_q;
                        ready_q  <= 1'b1;
                    end
                    state_q <= MUL_IDLE;
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    assign busy   = (state_q != MUL_IDLE);
    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_armleocpu_mul_iter.sv
// Randomized and directed bench for armleocpu_mul_iter at BITS_PER_CYCLE=1 and 4,
// checked against a plain-arithmetic 64-bit product model.
module tb_armleocpu_mul_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid   [2];
    logic        kill    [2];
    logic        signed0 [2];
    logic        signed1 [2];
    logic [31:0] factor0 [2];
    logic [31:0] factor1 [2];
    logic        busy    [2];
    logic        ready   [2];
    logic [63:0] result  [2];

    logic [63:0] exp_res [2];
    int          n_checks = 0;
    int          n_errors = 0;
    string       cur = "";

    always #5 clk = ~clk;

    armleocpu_mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_bpc1 (
        .clk(clk), .rst_n(rst_n), .valid(valid[0]), .kill(kill[0]),
        .signed0(signed0[0]), .signed1(signed1[0]),
        .factor0(factor0[0]), .factor1(factor1[0]),
        .busy(busy[0]), .ready(ready[0]), .result(result[0])
    );

    armleocpu_mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_bpc4 (
        .clk(clk), .rst_n(rst_n), .valid(valid[1]), .kill(kill[1]),
        .signed0(signed0[1]), .signed1(signed1[1]),
        .factor0(factor0[1]), .factor1(factor1[1]),
        .busy(busy[1]), .ready(ready[1]), .result(result[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %h expected %h", cur, tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic int iter_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Drive a request now; it is sampled at the next posedge, after which operands are scrambled.
    task automatic launch(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb);
        factor0[d] = a;
        factor1[d] = b;
        signed0[d] = sa;
        signed1[d] = sb;
        valid[d]   = 1'b1;
        @(posedge clk);
        #1;
        valid[d]   = 1'b0;
        factor0[d] = $urandom;
        factor1[d] = $urandom;
        signed0[d] = 1'($urandom_range(0, 1));
        signed1[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic await_ready(input int d, input int exp_lat, input logic [63:0] exp, input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            n++;
            #1;
            seen = ready[d];
        end
        check({tag, "_ready"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_lat"}, 64'(n), 64'(exp_lat));
            check({tag, "_res"}, result[d], exp);
        end
        exp_res[d] = exp;
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input string tag);
        @(negedge clk);
        launch(d, a, b, sa, sb);
        check({tag, "_busy"}, 64'(busy[d]), 64'd1);
        await_ready(d, iter_of(d) + 1, ref_mul(a, b, sa, sb), tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(ready[d]), 64'd0);
        check({tag, "_hold"}, result[d], exp_res[d]);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic [31:0] a;
        logic [31:0] b;
        logic sa;
        logic sb;

        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 0; kill[i] = 0; signed0[i] = 0; signed1[i] = 0;
            factor0[i] = '0; factor1[i] = '0; exp_res[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cur = (d == 0) ? "bpc1" : "bpc4";
            check("rst_busy", 64'(busy[d]), 64'd0);
            check("rst_ready", 64'(ready[d]), 64'd0);
            check("rst_result", result[d], 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;

        for (int d = 0; d < 2; d++) begin
            cur = (d == 0) ? "bpc1" : "bpc4";

            // Directed corner products
            run_op(d, 32'd64, 32'd53, 1'b0, 1'b0, "u64x53");
            check("u64x53_const", result[d], 64'h0000_0000_0000_0D40);
            run_op(d, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "uff");
            check("uff_const", result[d], 64'hFFFF_FFFE_0000_0001);
            run_op(d, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "sm1");
            check("sm1_const", result[d], 64'h1);
            run_op(d, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, "smin");
            check("smin_const", result[d], 64'h4000_0000_0000_0000);
            run_op(d, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "su");
            check("su_const", result[d], 64'hFFFF_FFFF_0000_0001);
            run_op(d, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, "s7m3");
            check("s7m3_const", result[d], 64'hFFFF_FFFF_FFFF_FFEB);

            // Abort at CALC cycle 5: no ready, result untouched
            @(negedge clk);
            launch(d, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
            repeat (4) @(posedge clk);
            #1;
            kill[d] = 1'b1;
            @(posedge clk);
            #1;
            kill[d] = 1'b0;
            check("kill_busy", 64'(busy[d]), 64'd0);
            check("kill_ready", 64'(ready[d]), 64'd0);
            check("kill_result", result[d], exp_res[d]);
            pulses = 0;
            for (int i = 0; i < iter_of(d) + 4; i++) begin
                @(posedge clk);
                #1;
                if (ready[d]) pulses++;
            end
            check("kill_nopulse", 64'(pulses), 64'd0);

            // kill and valid together while idle: nothing accepted
            @(negedge clk);
            factor0[d] = 32'd3; factor1[d] = 32'd5;
            valid[d] = 1'b1; kill[d] = 1'b1;
            @(posedge clk);
            #1;
            valid[d] = 1'b0; kill[d] = 1'b0;
            check("killvalid_busy", 64'(busy[d]), 64'd0);

            // A second valid mid-operation is ignored
            @(negedge clk);
            launch(d, 32'd1000, 32'd3000, 1'b0, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            factor0[d] = 32'd9; factor1[d] = 32'd9; valid[d] = 1'b1;
            @(posedge clk);
            #1;
            valid[d] = 1'b0;
            await_ready(d, iter_of(d) - 3, ref_mul(32'd1000, 32'd3000, 1'b0, 1'b0), "midvalid");
            @(posedge clk);
            #1;
            check("midvalid_idle", 64'(busy[d]), 64'd0);

            // Asynchronous reset in the middle of CALC
            @(negedge clk);
            launch(d, 32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b0);
            repeat (3) @(posedge clk);
            #2;
            rst_n = 1'b1;
            #1;
            check("arst_busy", 64'(busy[d]), 64'd0);
            check("arst_ready", 64'(ready[d]), 64'd0);
            check("arst_result", result[d], 64'd0);
            exp_res[0] = '0;
            exp_res[1] = '0;
            @(negedge clk);
            rst_n = 1'b0;

            // Back-to-back: new valid presented during the ready cycle
            @(negedge clk);
            launch(d, 32'd12345, 32'd6789, 1'b0, 1'b0);
            await_ready(d, iter_of(d) + 1, ref_mul(32'd12345, 32'd6789, 1'b0, 1'b0), "b2b_a");
            launch(d, 32'hFFFF_FFF0, 32'd77, 1'b1, 1'b0);
            check("b2b_busy", 64'(busy[d]), 64'd1);
            await_ready(d, iter_of(d) + 1, ref_mul(32'hFFFF_FFF0, 32'd77, 1'b1, 1'b0), "b2b_b");

            // Randomized operands and signedness
            for (int k = 0; k < 10; k++) begin
                a  = $urandom;
                b  = $urandom;
                sa = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    1: a = 32'h8000_0000;
                    2: b = 32'hFFFF_FFFF;
                    3: a = 32'd0;
                    default: ;
                endcase
                run_op(d, a, b, sa, sb, $sformatf("rnd%0d", k));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
